// File: rtl/cache_pkg.sv
// Shared types for the L2 miss path: requester ids, arbiter states and width defaults.
package cache_pkg;
    localparam int ADDR_W_DEF = 26;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic {SRC_IC = 1'b0, SRC_DC = 1'b1} src_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; bit 0 = I-cache, bit 1 = D-cache. Priority state lives in the parent.
module rr_arb2
    import cache_pkg::*;
(
    input  logic [1:0] req,
    input  src_t       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        // On a tie, the source that did not win last time goes first.
        if (&req) gnt = (last == SRC_DC) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/l2_miss_arbiter.sv
// Shares the L2 request port between I-cache and D-cache miss paths: round-robin grant,
// single outstanding transaction, response routing, grant/stall statistics and a response watchdog.
module l2_miss_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rsp_valid,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_we,
    output logic              dc_gnt,
    output logic              dc_rsp_valid,
    output logic              l2_valid,
    input  logic              l2_ready,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_we,
    input  logic              l2_rsp_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  ic_grants,
    output logic [CNT_W-1:0]  dc_grants,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    src_t              src_q;
    src_t              rr_last_q;
    logic [WD_W-1:0]   wd_q;
    logic              terr_q;
    logic [CNT_W-1:0]  icg_q, dcg_q, stall_q;

    logic [1:0] win;
    logic       idle, rsp_hit, stall_ev;

    rr_arb2 u_arb (
        .req  ({dc_req, ic_req}),
        .last (rr_last_q),
        .gnt  (win)
    );

    assign idle         = (state_q == IDLE);
    assign ic_gnt       = idle & win[0];
    assign dc_gnt       = idle & win[1];
    assign rsp_hit      = (state_q == WAIT_RSP) & l2_rsp_valid;
    assign ic_rsp_valid = rsp_hit & (src_q == SRC_IC);
    assign dc_rsp_valid = rsp_hit & (src_q == SRC_DC);
    assign stall_ev     = (ic_req & ~ic_gnt) | (dc_req & ~dc_gnt);

    assign l2_valid     = (state_q == ISSUE);
    assign l2_addr      = addr_q;
    assign l2_we        = we_q;
    assign busy         = ~idle;
    assign timeout_err  = terr_q;
    assign ic_grants    = icg_q;
    assign dc_grants    = dcg_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            src_q     <= SRC_IC;
            rr_last_q <= SRC_DC;
            wd_q      <= '0;
            terr_q    <= 1'b0;
            icg_q     <= '0;
            dcg_q     <= '0;
            stall_q   <= '0;
        end else begin
            if (stall_ev && ~&stall_q) stall_q <= stall_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (ic_gnt | dc_gnt) begin
                        addr_q    <= dc_gnt ? dc_addr : ic_addr;
                        we_q      <= dc_gnt & dc_we;
                        src_q     <= dc_gnt ? SRC_DC : SRC_IC;
                        rr_last_q <= dc_gnt ? SRC_DC : SRC_IC;
                        if (ic_gnt && ~&icg_q) icg_q <= icg_q + CNT_W'(1);
                        if (dc_gnt && ~&dcg_q) dcg_q <= dcg_q + CNT_W'(1);
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (l2_ready) begin
                        // Writebacks complete on acceptance; only reads wait for a fill.
                        state_q <= we_q ? IDLE : WAIT_RSP;
                        wd_q    <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (l2_rsp_valid) begin
                        state_q <= IDLE;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        terr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_miss_arbiter.sv
// Scoreboard bench for l2_miss_arbiter: expected grants, L2 requests and fill responses are queued
// when stimulus is driven and retired by a negedge monitor as the DUT produces them.
module tb_l2_miss_arbiter;
    localparam int AW = 26;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ic_req, dc_req, dc_we, l2_ready, l2_rsp_valid;
    logic [AW-1:0] ic_addr, dc_addr;
    logic          ic_gnt, dc_gnt, ic_rsp_valid, dc_rsp_valid, l2_valid, l2_we, busy, timeout_err;
    logic [AW-1:0] l2_addr;
    logic [CW-1:0] ic_grants, dc_grants, stall_cycles;

    int nchk = 0;
    int nerr = 0;

    logic        exp_gnt[$];
    logic        exp_rsp[$];
    logic [AW:0] exp_l2[$];

    always #5 clk = ~clk;

    l2_miss_arbiter #(.ADDR_W(AW), .TIMEOUT(255), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rsp_valid(ic_rsp_valid),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_gnt(dc_gnt), .dc_rsp_valid(dc_rsp_valid),
        .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_addr(l2_addr), .l2_we(l2_we),
        .l2_rsp_valid(l2_rsp_valid), .busy(busy), .timeout_err(timeout_err),
        .ic_grants(ic_grants), .dc_grants(dc_grants), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every grant, L2 acceptance and fill pulse must match the queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (ic_gnt | dc_gnt) begin
                chk("gnt_onehot", {62'd0, ic_gnt, dc_gnt} == 64'd3, 0);
                if (exp_gnt.size() == 0) chk("gnt_unexp", 1, 0);
                else chk("gnt_src", dc_gnt, exp_gnt.pop_front());
            end
            if (l2_valid && l2_ready) begin
                if (exp_l2.size() == 0) chk("l2_unexp", 1, 0);
                else chk("l2_req", {l2_we, l2_addr}, exp_l2.pop_front());
            end
            if (ic_rsp_valid | dc_rsp_valid) begin
                chk("rsp_onehot", {62'd0, ic_rsp_valid, dc_rsp_valid} == 64'd3, 0);
                if (exp_rsp.size() == 0) chk("rsp_unexp", 1, 0);
                else chk("rsp_src", dc_rsp_valid, exp_rsp.pop_front());
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 400; c++) begin
            smp();
            if (!busy) begin
                cyc();
                return;
            end
            cyc();
        end
        chk(tag, 1, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ic_req = 0; dc_req = 0; dc_we = 0; l2_ready = 0; l2_rsp_valid = 0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    // Both sources request continuously; expected order alternates starting with I-cache.
    task automatic contend(input int n, input logic [AW-1:0] a_ic, input logic [AW-1:0] a_dc);
        int ngnt;
        for (int i = 0; i < n; i++) begin
            exp_gnt.push_back(i[0]);
            exp_rsp.push_back(i[0]);
            exp_l2.push_back({1'b0, i[0] ? a_dc : a_ic});
        end
        ic_req = 1; ic_addr = a_ic; dc_req = 1; dc_addr = a_dc; dc_we = 0;
        l2_ready = 1; l2_rsp_valid = 1;
        ngnt = 0;
        for (int c = 0; c < 100 && ngnt < n; c++) begin
            smp();
            if (ic_gnt | dc_gnt) ngnt++;
            cyc();
        end
        chk("contend_gnts", ngnt, n);
        ic_req = 0; dc_req = 0;
        wait_idle("contend_idle_tmo");
        l2_rsp_valid = 0;
    endtask

    initial begin
        ic_addr = '0; dc_addr = '0;
        do_reset();
        smp();
        chk("rst_busy", busy, 0);
        chk("rst_l2", {l2_valid, l2_we, l2_addr}, 0);
        chk("rst_cnt", {ic_grants, dc_grants}, 0);
        chk("rst_stall_terr", {stall_cycles, timeout_err}, 0);
        cyc();

        // Single I-cache read with a fill two cycles after the grant.
        ic_req = 1; ic_addr = 26'h0ABCDE; l2_ready = 1;
        exp_gnt.push_back(1'b0); exp_l2.push_back({1'b0, 26'h0ABCDE}); exp_rsp.push_back(1'b0);
        smp(); chk("t1_gnt_c0", ic_gnt, 1);
        cyc(); ic_req = 0;
        smp(); chk("t1_l2_c1", {l2_valid, l2_addr}, {1'b1, 26'h0ABCDE});
        cyc(); l2_rsp_valid = 1;
        smp(); chk("t1_rsp_c2", ic_rsp_valid, 1);
        cyc(); l2_rsp_valid = 0;
        smp(); chk("t1_busy", busy, 0);
        chk("t1_icg", ic_grants, 1);
        chk("t1_stall", stall_cycles, 0);
        cyc();

        // Persistent contention from reset: IC, DC, IC, DC; a request waits in cycles 0..9.
        do_reset();
        contend(4, 26'h0000123, 26'h2345678);
        chk("t2_icg", ic_grants, 2);
        chk("t2_dcg", dc_grants, 2);
        chk("t2_stall", stall_cycles, 10);

        // Writeback with L2 back-pressure; fill input held high must be ignored.
        dc_req = 1; dc_we = 1; dc_addr = 26'h3FFFFFF; l2_ready = 0; l2_rsp_valid = 1;
        exp_gnt.push_back(1'b1); exp_l2.push_back({1'b1, 26'h3FFFFFF});
        smp(); chk("t3_gnt", dc_gnt, 1);
        cyc(); dc_req = 0; dc_we = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) l2_ready = 1;
            smp();
            chk("t3_l2_hold", {l2_valid, l2_we, l2_addr}, {2'b11, 26'h3FFFFFF});
            chk("t3_no_rsp", dc_rsp_valid, 0);
            cyc();
        end
        smp(); chk("t3_busy_after", busy, 0);
        chk("t3_no_rsp_after", dc_rsp_valid, 0);
        cyc(); l2_rsp_valid = 0;

        // Read with no fill: 255 cycles in WAIT_RSP, then abort with a sticky error.
        ic_req = 1; ic_addr = 26'h0055AA0; l2_ready = 1;
        exp_gnt.push_back(1'b0); exp_l2.push_back({1'b0, 26'h0055AA0});
        smp(); chk("t4_gnt", ic_gnt, 1);
        cyc(); ic_req = 0;
        for (int c = 1; c <= 256; c++) begin
            smp();
            if (c == 256) chk("t4_last_wait", {busy, timeout_err}, 2'b10);
            cyc();
        end
        smp(); chk("t4_abort", {busy, timeout_err}, 2'b01);
        cyc();
        dc_req = 1; dc_addr = 26'h1234567; dc_we = 0; l2_rsp_valid = 1;
        exp_gnt.push_back(1'b1); exp_l2.push_back({1'b0, 26'h1234567}); exp_rsp.push_back(1'b1);
        smp(); chk("t4_next_gnt", dc_gnt, 1);
        cyc(); dc_req = 0;
        wait_idle("t4_idle_tmo");
        l2_rsp_valid = 0;
        chk("t4_sticky", timeout_err, 1);

        // Reset while waiting for a fill; the late fill must not surface.
        ic_req = 1; ic_addr = 26'h0F0F0F0;
        exp_gnt.push_back(1'b0); exp_l2.push_back({1'b0, 26'h0F0F0F0});
        smp(); cyc(); ic_req = 0;
        smp(); cyc();
        smp(); chk("t5_in_wait", busy, 1);
        reset_n = 0;
        cyc();
        smp();
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cnt", {ic_grants, dc_grants, stall_cycles}, 0);
        chk("t5_rst_terr", timeout_err, 0);
        cyc(); reset_n = 1; l2_rsp_valid = 1;
        for (int c = 0; c < 2; c++) begin
            smp(); chk("t5_late_rsp", {ic_rsp_valid, dc_rsp_valid, busy}, 0);
            cyc();
        end
        l2_rsp_valid = 0;

        // Stall counter preloaded near all-ones, then contention drives it into saturation.
        smp();
        force dut.stall_q = 32'hFFFF_FFFD;
        #1 release dut.stall_q;
        cyc();
        contend(2, 26'h0000AAA, 26'h0000BBB);
        chk("t6_stall_sat", stall_cycles, 32'hFFFF_FFFF);
        chk("t6_grants", {ic_grants, dc_grants}, {32'd1, 32'd1});

        chk("sb_drain", exp_gnt.size() + exp_rsp.size() + exp_l2.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/l2_miss_arbiter.md
Name: l2_miss_arbiter

Overview:
- Shares the single next-level (L2) request port between the instruction-cache and data-cache miss paths.
- Arbitrates the two line-address requesters round-robin, issues one transaction at a time with a valid/ready handshake, waits for the read fill, and routes the response back to the originator.
- Keeps per-source grant statistics, a stall counter, and a response-timeout watchdog for the statistics/print path.

Parameters:
- ADDR_W, 26, line-address width (address bits 31:6)
- TIMEOUT, 255, max cycles in WAIT_RSP before abort
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ic_req  in  1  I-cache miss request, held until ic_gnt
- ic_addr  in  ADDR_W  I-cache line address, stable while ic_req
- ic_gnt  out  1  one-cycle accept pulse to I-cache
- ic_rsp_valid  out  1  one-cycle fill-complete pulse to I-cache
- dc_req  in  1  D-cache request, held until dc_gnt
- dc_addr  in  ADDR_W  D-cache line address
- dc_we  in  1  1 = writeback, 0 = read fill
- dc_gnt  out  1  one-cycle accept pulse to D-cache
- dc_rsp_valid  out  1  one-cycle fill-complete pulse to D-cache
- l2_valid  out  1  request valid to L2
- l2_ready  in  1  L2 accepts request this cycle
- l2_addr  out  ADDR_W  registered request address
- l2_we  out  1  registered write flag
- l2_rsp_valid  in  1  L2 read data returned
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag
- ic_grants  out  CNT_W  count of I-cache grants
- dc_grants  out  CNT_W  count of D-cache grants
- stall_cycles  out  CNT_W  cycles with a pending, ungranted request

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state = IDLE; every output 0; l2_addr = 0; counters = 0; timeout_err = 0.
  - rr_last = DC, so the first tie goes to IC.
  - Any in-flight transaction is dropped silently, with no rsp pulse.
- FSM states are IDLE, ISSUE and WAIT_RSP.
- IDLE:
  - If any req is high, the winner is picked combinationally.
  - When only one req is high, that requester wins.
  - When both are high, the source that is not rr_last wins.
  - The winner's gnt is asserted in the same cycle. At the edge, addr, we and src are latched, rr_last is set to the winner, and that source's grant counter increments.
  - Next state = ISSUE.
- ISSUE:
  - l2_valid = 1, driven from the latched registers.
  - At an edge with l2_ready = 1, a read goes to WAIT_RSP and a write (dc_we latched = 1) goes to IDLE.
  - Writes never produce rsp_valid.
- WAIT_RSP:
  - l2_valid = 0; the watchdog counter increments each cycle.
  - When l2_rsp_valid = 1, the latched source's rsp_valid is pulsed combinationally in that cycle, and the next state is IDLE.
  - If the counter reaches TIMEOUT with no response, timeout_err is set (sticky until reset), no rsp pulse is issued, and the next state is IDLE.
  - The counter clears on entry.
- Latency:
  - A read takes at least 3 cycles: grant in cycle 0, l2_valid in cycle 1 (ready=1), and rsp accepted in cycle 2 at the earliest.
  - Back-to-back grants are separated by at least 2 cycles.
- l2_rsp_valid outside WAIT_RSP is ignored.
- A req dropping before gnt is legal; arbitration is re-evaluated every IDLE cycle.
- stall_cycles increments every cycle in which (ic_req & ~ic_gnt) | (dc_req & ~dc_gnt).
- All three counters saturate at all-ones.
- gnt is never asserted outside IDLE, and at most one gnt or rsp pulse is active per cycle.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W and CNT_W defaults
  - the src_t enum {SRC_IC, SRC_DC}
  - the arb_state_t enum {IDLE, ISSUE, WAIT_RSP}
- One sub-module, rr_arb2: a two-input round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot grant.
  - It is purely combinational; rr_last is held in the parent.

Test Plan:
- ic_req=1, ic_addr=26'h0ABCDE after reset, l2_ready=1, l2_rsp_valid 2 cycles later:
  - ic_gnt at cycle 0, l2_valid/l2_addr=26'h0ABCDE at cycle 1, ic_rsp_valid in the rsp cycle.
  - ic_grants=1.
- ic_req and dc_req both held high for 4 transactions:
  - Grants are IC, DC, IC, DC.
  - ic_grants=2, dc_grants=2.
  - stall_cycles counts every cycle in which a request waited.
- dc_req=1, dc_we=1, addr=26'h3FFFFFF, l2_ready low 3 cycles then high:
  - l2_valid held for 4 cycles with l2_we=1.
  - Returns to IDLE with no dc_rsp_valid.
  - busy=0 one cycle after acceptance.
- Read accepted and l2_rsp_valid never arrives:
  - After 255 WAIT_RSP cycles, timeout_err=1 and state returns to IDLE.
  - The next request is granted normally, and timeout_err stays 1.
- reset_n=0 asserted during WAIT_RSP:
  - The next cycle shows busy=0 and counters=0.
  - A late l2_rsp_valid produces no rsp pulse.
- stall_cycles preloaded near all-ones (force) with persistent contention:
  - The counter holds at 32'hFFFFFFFF and does not wrap.
